act_quant: RTL and testbench

Per-token activation quantizer that sits directly downstream of rms_norm and feeds the ternary (matmul-free) dense layers.
- Accepts one normalized FXP vector.
- Finds its absolute maximum with a sequential scan.
- Quantizes every element to signed Q_BITS integers as q = x*QMAX/absmax, using a shared sequential restoring divider.
- Outputs absmax as the dequantization scale for the downstream layer.

---
 rtl/act_quant.sv | 195 +++++++++++++++++++
 tb/tb_act_quant.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_quant.sv
`timescale 1ns/1ps
// act_quant: per-token absmax activation quantizer (sequential scan + shared divider).
// Define ACT_QUANT_ROUND_EN for round-half-away-from-zero magnitudes (else truncate).
module act_quant #(
    parameter int ARR_WIDTH = 8,
    parameter int FXP_N     = 16,
    parameter int FXP_FRAC  = 8,
    parameter int Q_BITS    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        start,
    input  logic [ARR_WIDTH*FXP_N-1:0]  input_arr,
    output logic                        busy,
    output logic                        done,
    output logic [ARR_WIDTH*Q_BITS-1:0] q_arr,
    output logic [FXP_N-1:0]            scale_out,
    output logic                        zero_vec
);

    localparam int IW = (ARR_WIDTH > 1) ? $clog2(ARR_WIDTH) : 1;
`ifdef ACT_QUANT_ROUND_EN
    localparam int DSTEPS = Q_BITS + 1;
`else
    localparam int DSTEPS = Q_BITS;
`endif
    localparam int SW   = $clog2(DSTEPS + 1);
    localparam int DW   = FXP_N + Q_BITS + 2;
    localparam int QMAX = (1 << (Q_BITS - 1)) - 1;

    localparam logic [DW-1:0]     QMAX_W    = DW'(QMAX);
    localparam logic [DSTEPS-1:0] QMAX_Q    = DSTEPS'(QMAX);
    localparam logic [IW-1:0]     LAST      = IW'(ARR_WIDTH - 1);
    localparam logic [SW-1:0]     STEP_LAST = SW'(DSTEPS);
    localparam logic [FXP_N-1:0]  MIN_NEG   = {1'b1, {(FXP_N-1){1'b0}}};
    localparam logic [FXP_N-1:0]  MAX_POS   = {1'b0, {(FXP_N-1){1'b1}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_QUANT = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (FXP_FRAC < 0 || FXP_FRAC >= FXP_N) begin : g_frac_chk
        $error("act_quant: FXP_FRAC out of range");
    end

    logic [2:0]        state;
    logic [FXP_N-1:0]  cap  [ARR_WIDTH];
    logic [Q_BITS-1:0] q_sh [ARR_WIDTH];
    logic [FXP_N-1:0]  amax;
    logic              zflag;
    logic [IW-1:0]     idx;
    logic [SW-1:0]     step;
    logic [DW-1:0]     rem;
    logic [DW-1:0]     dsh;
    logic [DSTEPS-1:0] quo;

    logic [FXP_N-1:0]  cur_x;
    logic [FXP_N-1:0]  cur_abs;
    logic [FXP_N-1:0]  max_nxt;
    logic [DW-1:0]     num;
    logic [DW-1:0]     den;
    logic [DW-1:0]     rem_sub;
    logic              ge;
    logic [IW-1:0]     wb_idx;
    logic [DSTEPS-1:0] mag_c;
    logic [Q_BITS-1:0] mag;
    logic [Q_BITS-1:0] wb_val;

    always_comb begin
        cur_x = cap[idx];
        if (cur_x == MIN_NEG)
            cur_abs = MAX_POS;
        else if (cur_x[FXP_N-1])
            cur_abs = -cur_x;
        else
            cur_abs = cur_x;
        max_nxt = (cur_abs > amax) ? cur_abs : amax;
`ifdef ACT_QUANT_ROUND_EN
        num = (DW'(cur_abs) << 1) * QMAX_W + DW'(amax);
        den = DW'(amax) << 1;
`else
        num = DW'(cur_abs) * QMAX_W;
        den = DW'(amax);
`endif
        ge      = (rem >= dsh);
        rem_sub = rem - dsh;
        // writeback of element i-1 overlaps the load of element i
        wb_idx  = (state == S_WB) ? LAST : idx - 1'b1;
        mag_c   = (quo > QMAX_Q) ? QMAX_Q : quo;
        mag     = mag_c[Q_BITS-1:0];
        wb_val  = cap[wb_idx][FXP_N-1] ? -mag : mag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            q_arr     <= '0;
            scale_out <= '0;
            zero_vec  <= 1'b0;
            amax      <= '0;
            zflag     <= 1'b0;
            idx       <= '0;
            step      <= '0;
            rem       <= '0;
            dsh       <= '0;
            quo       <= '0;
            for (int i = 0; i < ARR_WIDTH; i++) begin
                cap[i]  <= '0;
                q_sh[i] <= '0;
            end
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < ARR_WIDTH; i++) begin
                            cap[i]  <= input_arr[i*FXP_N +: FXP_N];
                            q_sh[i] <= '0;
                        end
                        idx   <= '0;
                        amax  <= '0;
                        zflag <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    amax <= max_nxt;
                    if (idx == LAST) begin
                        idx  <= '0;
                        step <= '0;
                        if (max_nxt == '0) begin
                            zflag <= 1'b1;
                            state <= S_WB;
                        end else begin
                            state <= S_QUANT;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_QUANT: begin
                    if (step == '0) begin
                        rem  <= num;
                        dsh  <= den << (DSTEPS - 1);
                        quo  <= '0;
                        step <= SW'(1);
                        if (idx != '0)
                            q_sh[wb_idx] <= wb_val;
                    end else begin
                        if (ge)
                            rem <= rem_sub;
                        quo <= {quo[DSTEPS-2:0], ge};
                        dsh <= dsh >> 1;
                        if (step == STEP_LAST) begin
                            if (idx == LAST) begin
                                state <= S_WB;
                            end else begin
                                idx  <= idx + 1'b1;
                                step <= '0;
                            end
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (!zflag)
                        q_sh[LAST] <= wb_val;
                    for (int i = 0; i < ARR_WIDTH; i++) begin
                        if (i == ARR_WIDTH - 1 && !zflag)
                            q_arr[i*Q_BITS +: Q_BITS] <= wb_val;
                        else
                            q_arr[i*Q_BITS +: Q_BITS] <= q_sh[i];
                    end
                    scale_out <= amax;
                    zero_vec  <= zflag;
                    done      <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_quant.sv
`timescale 1ns/1ps
// Scoreboard bench for act_quant: expected results from an integer model.
module tb_act_quant;

    localparam int AW   = 8;
    localparam int N    = 16;
    localparam int QB   = 8;
    localparam int QMAX = 127;
    localparam int AMAX = (1 << (N - 1)) - 1;
`ifdef ACT_QUANT_ROUND_EN
    localparam int LAT = 89;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 81;
    localparam bit RND = 1'b0;
`endif
    localparam int ZLAT = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            start;
    logic [AW*N-1:0] input_arr;
    logic            busy;
    logic            done;
    logic [AW*QB-1:0] q_arr;
    logic [N-1:0]    scale_out;
    logic            zero_vec;

    typedef struct {
        logic [AW*QB-1:0] q;
        logic [N-1:0]     scale;
        logic             zero;
    } exp_t;

    exp_t sb[$];
    int tests_run = 0;
    int fails = 0;

    int V1[AW] = '{256, -128, 64, 0, 512, -512, 1, 255};
    int VZ[AW] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int VS[AW] = '{100, 100, -32768, 100, 100, 100, 100, 100};

    act_quant dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start),
        .input_arr(input_arr), .busy(busy), .done(done),
        .q_arr(q_arr), .scale_out(scale_out), .zero_vec(zero_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [AW*N-1:0] mkvec(input int vals[AW]);
        logic [AW*N-1:0] v;
        for (int i = 0; i < AW; i++) v[i*N +: N] = N'(vals[i]);
        return v;
    endfunction

    function automatic exp_t model(input logic [AW*N-1:0] v);
        exp_t e;
        longint x, a, am, m;
        am = 0;
        for (int i = 0; i < AW; i++) begin
            x = longint'(signed'(v[i*N +: N]));
            a = (x < 0) ? -x : x;
            if (a > AMAX) a = AMAX;
            if (a > am) am = a;
        end
        e.scale = N'(am);
        e.zero = (am == 0);
        e.q = '0;
        if (am != 0) begin
            for (int i = 0; i < AW; i++) begin
                x = longint'(signed'(v[i*N +: N]));
                a = (x < 0) ? -x : x;
                if (a > AMAX) a = AMAX;
                m = RND ? (2 * a * QMAX + am) / (2 * am) : (a * QMAX) / am;
                if (m > QMAX) m = QMAX;
                e.q[i*QB +: QB] = (x < 0) ? QB'(-m) : QB'(m);
            end
        end
        return e;
    endfunction

    task automatic launch(input logic [AW*N-1:0] v);
        repeat (2) @(posedge clk);
        #1;
        input_arr = v;
        start = 1'b1;
        sb.push_back(model(v));
        @(posedge clk);
        #1;
        start = 1'b0;
        input_arr = ~v;
    endtask

    task automatic wait_done(input int bound, output int lat);
        lat = 0;
        while (lat < bound) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) return;
        end
        lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; start = 1'b0; input_arr = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, zero_vec} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000", {busy, done, zero_vec});
        end
        tests_run++;
        if (q_arr !== '0 || scale_out !== '0) begin
            fails++;
            $display("FAIL reset_data got q=%h s=%h want 0", q_arr, scale_out);
        end
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_basic;
        exp_t e;
        int lat;
        launch(mkvec(V1));
        wait_done(200, lat);
        e = sb.pop_front();
        tests_run++;
        if (lat !== LAT) begin
            fails++; $display("FAIL basic_lat got %0d want %0d", lat, LAT);
        end
        tests_run++;
        if (q_arr !== e.q) begin
            fails++; $display("FAIL basic_q got %h want %h", q_arr, e.q);
        end
        tests_run++;
        if (scale_out !== 16'd512 || zero_vec !== 1'b0) begin
            fails++;
            $display("FAIL basic_scale got %0d/%b want 512/0", scale_out, zero_vec);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({done, busy} !== 2'b00) begin
            fails++; $display("FAIL basic_pulse got %b want 00", {done, busy});
        end
    endtask

    task automatic test_zero;
        exp_t e;
        int lat;
        launch(mkvec(VZ));
        wait_done(200, lat);
        e = sb.pop_front();
        tests_run++;
        if (lat !== ZLAT) begin
            fails++; $display("FAIL zero_lat got %0d want %0d", lat, ZLAT);
        end
        tests_run++;
        if (q_arr !== e.q || scale_out !== e.scale || zero_vec !== 1'b1) begin
            fails++;
            $display("FAIL zero_out got %h/%0d/%b want %h/%0d/1",
                     q_arr, scale_out, zero_vec, e.q, e.scale);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL zero_pulse got %b want 0", done);
        end
    endtask

    task automatic test_saturate;
        exp_t e;
        int lat;
        logic has_min;
        launch(mkvec(VS));
        wait_done(200, lat);
        e = sb.pop_front();
        tests_run++;
        if (q_arr !== e.q || q_arr[2*QB +: QB] !== 8'h81) begin
            fails++; $display("FAIL sat_q got %h want %h", q_arr, e.q);
        end
        tests_run++;
        if (scale_out !== 16'd32767 || lat !== LAT) begin
            fails++;
            $display("FAIL sat_scale got %0d lat %0d want 32767 lat %0d",
                     scale_out, lat, LAT);
        end
        has_min = 1'b0;
        for (int i = 0; i < AW; i++)
            if (q_arr[i*QB +: QB] == 8'h80) has_min = 1'b1;
        tests_run++;
        if (has_min !== 1'b0) begin
            fails++; $display("FAIL sat_nomin got %h want no 80", q_arr);
        end
    endtask

    task automatic test_start_ignored;
        exp_t e;
        int n, ndone, lat;
        launch(mkvec(V1));
        n = 0; ndone = 0; lat = -1;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 4) start = 1'b1;
            if (n == 5) start = 1'b0;
            if (n == LAT - 1) start = 1'b1;
            if (n == LAT + 1) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
        end
        e = sb.pop_front();
        tests_run++;
        if (ndone !== 1 || lat !== LAT) begin
            fails++;
            $display("FAIL ign_done got %0d pulses at %0d want 1 at %0d", ndone, lat, LAT);
        end
        tests_run++;
        if (busy !== 1'b0 || q_arr !== e.q) begin
            fails++; $display("FAIL ign_out got busy=%b q=%h want 0/%h", busy, q_arr, e.q);
        end
        launch(mkvec(VS));
        wait_done(200, lat);
        e = sb.pop_front();
        tests_run++;
        if (lat !== LAT || q_arr !== e.q) begin
            fails++;
            $display("FAIL ign_restart got lat %0d q %h want %0d %h", lat, q_arr, LAT, e.q);
        end
    endtask

    task automatic test_enable;
        exp_t e;
        int n, first, hi;
        launch(mkvec(V1));
        n = 0; first = 0; hi = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 30) enable = 1'b0;
            if (n == 40) enable = 1'b1;
            if (done) begin
                hi++;
                if (first == 0) begin
                    first = n;
                    enable = 1'b0;
                end
            end
            if (first != 0 && n == first + 3) enable = 1'b1;
            if (first != 0 && n == first + 6) break;
        end
        enable = 1'b1;
        e = sb.pop_front();
        tests_run++;
        if (first !== LAT + 10) begin
            fails++; $display("FAIL en_lat got %0d want %0d", first, LAT + 10);
        end
        tests_run++;
        if (hi !== 4) begin
            fails++; $display("FAIL en_hold got %0d want 4", hi);
        end
        tests_run++;
        if (q_arr !== e.q || scale_out !== e.scale) begin
            fails++; $display("FAIL en_out got %h/%0d want %h/%0d", q_arr, scale_out, e.q, e.scale);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int lat;
        launch(mkvec(V1));
        repeat (39) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        tests_run++;
        if ({busy, done, zero_vec} !== 3'b000 || q_arr !== '0 || scale_out !== '0) begin
            fails++;
            $display("FAIL rstmid_out got %b q=%h s=%0d want all 0",
                     {busy, done, zero_vec}, q_arr, scale_out);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(mkvec(V1));
        wait_done(200, lat);
        e = sb.pop_front();
        tests_run++;
        if (lat !== LAT || q_arr !== e.q || scale_out !== e.scale) begin
            fails++;
            $display("FAIL rstmid_rerun got lat %0d q %h want %0d %h", lat, q_arr, LAT, e.q);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_saturate();
        test_start_ignored();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
